// File: rtl/inst_fetch.sv
// inst_fetch: MIPS instruction-fetch stage.
// Owns the PC, addresses the combinational instruction ROM and registers the
// returned word into the IF/ID pipeline register. Inaccessible fetches are
// vectored to EXC_VECTOR after a short drain period. A fault at the vector
// itself halts fetch until reset.
module inst_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_accessable,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [7:0]  fault_count,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // The drain counter is 4 bits wide, enough for the 1..15 range.
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [7:0]  fault_count_q, fault_count_d;
  logic        halted_q, halted_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic: redirect beats stall beats fetch in RUN; DRAIN and HALT
  // ignore everything except the drain counter and reset respectively.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_cnt_d   = drain_cnt_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    fault_d       = 1'b0;
    fault_pc_d    = fault_pc_q;
    fault_count_d = fault_count_q;
    halted_d      = halted_q;

    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          // Taken even under stall; the ROM response for the old PC is dropped.
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
        end else if (stall) begin
          // Hold PC and IF/ID; no fault is evaluated while stalled.
        end else if (imem_accessable) begin
          id_instr_d    = imem_data;
          id_pc_plus4_d = pc_plus4;
          id_valid_d    = 1'b1;
          pc_d          = pc_plus4;
        end else begin
          id_valid_d    = 1'b0;
          fault_d       = 1'b1;
          fault_pc_d    = pc_q;
          fault_count_d = (fault_count_q == 8'hFF) ? fault_count_q
                                                   : fault_count_q + 8'd1;
          if (pc_q == EXC_VECTOR) begin
            // The handler itself is unreachable: nothing sensible to fetch.
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d        = EXC_VECTOR;
            drain_cnt_d = DRAIN_INIT;
            state_d     = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Vector wins over any in-flight branch, and stall cannot extend this.
        id_valid_d  = 1'b0;
        pc_d        = EXC_VECTOR;
        drain_cnt_d = drain_cnt_q - 4'd1;
        if (drain_cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end

      HALT: begin
        id_valid_d = 1'b0;
      end

      default: begin
        state_d    = HALT;
        id_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
    endcase
  end

  // State and pipeline registers; reset returns everything to boot values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      drain_cnt_q   <= 4'd0;
      id_instr_q    <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'd0;
      fault_count_q <= 8'd0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_cnt_q   <= drain_cnt_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      fault_count_q <= fault_count_d;
      halted_q      <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_valid    = id_valid_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fault_count = fault_count_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with a small behavioural ROM.
module tb_inst_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_accessable;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [7:0]  fault_count;
  logic        halted;

  logic        vec_bad;
  int          checks;
  int          failures;

  inst_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .imem_accessable (imem_accessable),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_instr        (id_instr),
    .id_pc_plus4     (id_pc_plus4),
    .id_valid        (id_valid),
    .fault           (fault),
    .fault_pc        (fault_pc),
    .fault_count     (fault_count),
    .halted          (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Boot ROM: 0x0..0x8 hold lui/addiu/jr; 0xC is unmapped; 0x00400000..0x0040003C
  // returns 0xA0000000 | addr. Misaligned addresses are inaccessible.
  always_comb begin
    imem_data       = 32'd0;
    imem_accessable = 1'b0;
    case (imem_addr)
      32'h0000_0000: begin imem_data = 32'h3c11_0040; imem_accessable = 1'b1; end
      32'h0000_0004: begin imem_data = 32'h2631_0000; imem_accessable = 1'b1; end
      32'h0000_0008: begin imem_data = 32'h0220_0008; imem_accessable = 1'b1; end
      default: begin
        if (imem_addr[1:0] == 2'b00 && imem_addr >= 32'h0040_0000 &&
            imem_addr < 32'h0040_0040) begin
          imem_data       = 32'hA000_0000 | imem_addr;
          imem_accessable = !(vec_bad && imem_addr == 32'h0040_0004);
        end
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    vec_bad = 1'b0;
    #12;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", id_instr, 32'h0);
    check("rst_pc4", id_pc_plus4, 32'h0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fpc", fault_pc, 32'h0);
    check("rst_fcnt", {24'd0, fault_count}, 32'd0);
    check("rst_halt", {31'd0, halted}, 32'd0);
    reset = 1'b0;

    // Boot sequence
    tick();
    check("boot0_instr", id_instr, 32'h3c11_0040);
    check("boot0_pc4", id_pc_plus4, 32'h4);
    check("boot0_valid", {31'd0, id_valid}, 32'd1);
    check("boot0_addr", imem_addr, 32'h4);
    tick();
    check("boot1_instr", id_instr, 32'h2631_0000);
    check("boot1_pc4", id_pc_plus4, 32'h8);
    tick();
    check("boot2_instr", id_instr, 32'h0220_0008);
    check("boot2_pc4", id_pc_plus4, 32'hC);
    check("boot2_addr", imem_addr, 32'hC);

    // Redirect while ROM reports 0xC inaccessible: redirect wins, no fault
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0000;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", {31'd0, id_valid}, 32'd0);
    check("redir_nofault", {31'd0, fault}, 32'd0);
    check("redir_fcnt", {24'd0, fault_count}, 32'd0);
    check("redir_addr", imem_addr, 32'h0040_0000);
    tick();
    check("redir_next_valid", {31'd0, id_valid}, 32'd1);
    check("redir_next_pc4", id_pc_plus4, 32'h0040_0004);
    check("redir_next_instr", id_instr, 32'hA040_0000);

    // Stall for 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", imem_addr, 32'h0040_0004);
      check("stall_instr", id_instr, 32'hA040_0000);
      check("stall_pc4", id_pc_plus4, 32'h0040_0004);
    end
    stall = 1'b0;
    tick();
    check("unstall_instr", id_instr, 32'hA040_0004);
    check("unstall_pc4", id_pc_plus4, 32'h0040_0008);

    // Redirect during stall is taken immediately
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0010;
    tick();
    stall = 1'b0;
    redirect_valid = 1'b0;
    check("stredir_addr", imem_addr, 32'h0040_0010);
    check("stredir_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("stredir_pc4", id_pc_plus4, 32'h0040_0014);
    check("stredir_instr", id_instr, 32'hA040_0010);

    // Fault at 0xC
    redirect_valid = 1'b1;
    redirect_target = 32'hC;
    tick();
    redirect_valid = 1'b0;
    check("f1_pre_addr", imem_addr, 32'hC);
    tick();
    check("f1_fault", {31'd0, fault}, 32'd1);
    check("f1_fpc", fault_pc, 32'hC);
    check("f1_fcnt", {24'd0, fault_count}, 32'd1);
    check("f1_valid", {31'd0, id_valid}, 32'd0);
    check("f1_addr", imem_addr, 32'h0040_0004);
    // stall and redirect during drain are ignored
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    tick();
    check("drain1_fault", {31'd0, fault}, 32'd0);
    check("drain1_valid", {31'd0, id_valid}, 32'd0);
    check("drain1_addr", imem_addr, 32'h0040_0004);
    tick();
    stall = 1'b0;
    redirect_valid = 1'b0;
    check("drain2_valid", {31'd0, id_valid}, 32'd0);
    check("drain2_addr", imem_addr, 32'h0040_0004);
    tick();
    check("vec_valid", {31'd0, id_valid}, 32'd1);
    check("vec_pc4", id_pc_plus4, 32'h0040_0008);
    check("vec_instr", id_instr, 32'hA040_0004);

    // Misaligned redirect faults on the next fetch
    redirect_valid = 1'b1;
    redirect_target = 32'h0040_0002;
    tick();
    redirect_valid = 1'b0;
    check("mis_addr", imem_addr, 32'h0040_0002);
    tick();
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_fpc", fault_pc, 32'h0040_0002);
    check("mis_fcnt", {24'd0, fault_count}, 32'd2);
    tick();
    tick();
    tick();
    check("mis_vec_valid", {31'd0, id_valid}, 32'd1);
    check("mis_vec_pc4", id_pc_plus4, 32'h0040_0008);

    // Asynchronous reset mid-cycle
    #3 reset = 1'b1;
    #1;
    check("arst_addr", imem_addr, 32'h0);
    check("arst_fcnt", {24'd0, fault_count}, 32'd0);
    check("arst_fpc", fault_pc, 32'h0);
    check("arst_valid", {31'd0, id_valid}, 32'd0);
    reset = 1'b0;

    // Double fault with the vector made inaccessible
    vec_bad = 1'b1;
    tick();
    tick();
    tick();
    check("df_boot_pc4", id_pc_plus4, 32'hC);
    tick();
    check("df1_fault", {31'd0, fault}, 32'd1);
    check("df1_fcnt", {24'd0, fault_count}, 32'd1);
    check("df1_halt", {31'd0, halted}, 32'd0);
    check("df1_addr", imem_addr, 32'h0040_0004);
    tick();
    tick();
    tick();
    check("df2_fault", {31'd0, fault}, 32'd1);
    check("df2_fpc", fault_pc, 32'h0040_0004);
    check("df2_fcnt", {24'd0, fault_count}, 32'd2);
    check("df2_halt", {31'd0, halted}, 32'd1);
    check("df2_valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    vec_bad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("halt_addr", imem_addr, 32'h0040_0004);
      check("halt_sticky", {31'd0, halted}, 32'd1);
      check("halt_nofault", {31'd0, fault}, 32'd0);
      check("halt_fcnt", {24'd0, fault_count}, 32'd2);
      check("halt_valid", {31'd0, id_valid}, 32'd0);
    end
    redirect_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("hrst_halt", {31'd0, halted}, 32'd0);
    check("hrst_addr", imem_addr, 32'h0);
    reset = 1'b0;
    tick();
    check("hrst_run_valid", {31'd0, id_valid}, 32'd1);
    check("hrst_run_pc4", id_pc_plus4, 32'h4);

    // Force 300 faults: count saturates at 255
    for (int i = 0; i < 300; i++) begin
      redirect_valid = 1'b1;
      redirect_target = 32'h1;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      tick();
      if (i == 0) check("sat_first", {24'd0, fault_count}, 32'd1);
    end
    check("sat_fcnt", {24'd0, fault_count}, 32'd255);
    check("sat_fpc", fault_pc, 32'h1);
    check("sat_halt", {31'd0, halted}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
